// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that feeds one UART stream driver from NUM_SRC byte sources.
// Define UART_ARB_HEADER_EN to prefix each packet with a {4'hA, id} header byte.
module uart_tx_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC*8-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_rdclk,
    input  logic                   tx_ready,
    output logic                   tx_inclk,
    output logic [7:0]             tx_data,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   trunc_err
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam int CW  = $clog2(MAX_PKT_LEN + 1);
    localparam logic [IDW:0]  NSRC = (IDW + 1)'(NUM_SRC);
    localparam logic [CW-1:0] CMAX = CW'(MAX_PKT_LEN);

    typedef enum logic [2:0] {
        IDLE,
`ifdef UART_ARB_HEADER_EN
        HDR,
`endif
        XFER,
        WAIT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     gidx, gidx_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
    logic [NUM_SRC-1:0] grant_nxt, rdclk_nxt;
    logic               inclk_nxt, trunc_nxt;
    logic [7:0]         data_nxt;

    logic               found;
    logic [IDW-1:0]     pick, cand;
    logic [IDW:0]       sum;

    logic [7:0]         g_data;
    logic               g_req, g_last;

    assign g_data  = src_data[{gidx, 3'b000} +: 8];
    assign g_req   = src_req[gidx];
    assign g_last  = src_last[gidx];
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

    // Scan from ptr upward with wraparound; the first active request wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = {1'b0, ptr} + (IDW + 1)'(k);
            if (sum >= NSRC)
                sum = sum - NSRC;
            cand = sum[IDW-1:0];
            if (!found && src_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        rdclk_nxt = '0;
        inclk_nxt = 1'b0;
        data_nxt  = tx_data;
        trunc_nxt = trunc_err;

        case (state)
            IDLE: begin
                if (found) begin
                    gidx_nxt  = pick;
                    grant_nxt = NUM_SRC'(1) << pick;
                    cnt_nxt   = '0;
`ifdef UART_ARB_HEADER_EN
                    state_nxt = HDR;
`else
                    state_nxt = XFER;
`endif
                end
            end
`ifdef UART_ARB_HEADER_EN
            HDR: begin
                if (tx_ready) begin
                    inclk_nxt = 1'b1;
                    data_nxt  = {4'hA, 4'(gidx)};
                    state_nxt = WAIT;
                end
            end
`endif
            // A dropped request simply parks us here until the source returns.
            XFER: begin
                if (tx_ready && g_req) begin
                    inclk_nxt = 1'b1;
                    data_nxt  = g_data;
                    rdclk_nxt = grant;
                    cnt_nxt   = cnt_inc;
                    if (g_last) begin
                        state_nxt = DONE;
                    end else if (cnt_inc == CMAX) begin
                        trunc_nxt = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: state_nxt = XFER;
            DONE: begin
                grant_nxt = '0;
                ptr_nxt   = (gidx == IDW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gidx      <= '0;
            ptr       <= '0;
            cnt       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx_inclk  <= 1'b0;
            tx_data   <= '0;
            src_rdclk <= '0;
            trunc_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            gidx      <= gidx_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            busy      <= (state_nxt != IDLE);
            tx_inclk  <= inclk_nxt;
            tx_data   <= data_nxt;
            src_rdclk <= rdclk_nxt;
            trunc_err <= trunc_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single packet, contention, truncation,
// backpressure, source stall and mid-packet reset.
module tb_uart_tx_arbiter;

    localparam int NS   = 4;
    localparam int MAXL = 4;
`ifdef UART_ARB_HEADER_EN
    localparam logic [7:0] FIRST_BYTE = 8'hA2;
    localparam int         GRANT_GAP  = 5;
`else
    localparam logic [7:0] FIRST_BYTE = 8'h11;
    localparam int         GRANT_GAP  = 3;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NS-1:0]   src_req;
    logic [NS*8-1:0] src_data;
    logic [NS-1:0]   src_last;
    logic [NS-1:0]   src_rdclk;
    logic            tx_ready;
    logic            tx_inclk;
    logic [7:0]      tx_data;
    logic [NS-1:0]   grant;
    logic            busy;
    logic            trunc_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAXL)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_req   (src_req),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_rdclk (src_rdclk),
        .tx_ready  (tx_ready),
        .tx_inclk  (tx_inclk),
        .tx_data   (tx_data),
        .grant     (grant),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [7:0]  mem [NS][8];
    int          len [NS];
    int          pos [NS];
    int          rd_cnt [NS];
    bit          has_last [NS];
    bit          give_up [NS];
    logic [7:0]  pay_q [$];
    logic [7:0]  hdr_q [$];
    int          gnt_q [$];
    int          gnt_cyc [$];
    logic [NS-1:0] prev_grant = '0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source model: drive the byte at pos, or drop the request once the packet is exhausted.
    task automatic present(input int i);
        if (pos[i] < len[i]) begin
            src_req[i]         = 1'b1;
            src_data[8*i +: 8] = mem[i][pos[i]];
            src_last[i]        = has_last[i] && (pos[i] == len[i] - 1);
        end else begin
            src_req[i]  = 1'b0;
            src_last[i] = 1'b0;
        end
    endtask

    task automatic load_pkt(input int i, input int n, input bit last_flag, input int base, input int stp);
        for (int j = 0; j < n; j++)
            mem[i][j] = 8'(base + j * stp);
        len[i]      = n;
        pos[i]      = 0;
        has_last[i] = last_flag;
        present(i);
    endtask

    // One clock, then sample outputs #1 later and let the sources react.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (tx_inclk) begin
            if (|src_rdclk) pay_q.push_back(tx_data);
            else            hdr_q.push_back(tx_data);
        end
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < NS; i++)
                if (grant[i]) gnt_q.push_back(i);
            gnt_cyc.push_back(cycle);
        end
        prev_grant = grant;
        for (int i = 0; i < NS; i++) begin
            if (src_rdclk[i]) begin
                rd_cnt[i]++;
                pos[i]++;
                present(i);
            end
            if (trunc_err && give_up[i]) begin
                src_req[i]  = 1'b0;
                give_up[i]  = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input int max_cyc, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || (|src_req)) && n < max_cyc);
        check_output({tag, " timeout"}, 32'(busy || (|src_req)), 0);
    endtask

    task automatic wait_rd(input int i, input int target, input string tag);
        int n = 0;
        while (rd_cnt[i] < target && n < 60) begin
            step();
            n++;
        end
        check_output(tag, 32'(rd_cnt[i] >= target), 1);
    endtask

    initial begin
        int strobes;
        int lost;
        int base;

        reset    = 1'b0;
        tx_ready = 1'b1;
        src_req  = '0;
        src_data = '0;
        src_last = '0;
        for (int i = 0; i < NS; i++) begin
            len[i] = 0; pos[i] = 0; rd_cnt[i] = 0; has_last[i] = 1'b0; give_up[i] = 1'b0;
            for (int j = 0; j < 8; j++) mem[i][j] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check_output("rst grant",     32'(grant), 0);
        check_output("rst busy",      32'(busy), 0);
        check_output("rst tx_inclk",  32'(tx_inclk), 0);
        check_output("rst tx_data",   32'(tx_data), 0);
        check_output("rst src_rdclk", 32'(src_rdclk), 0);
        check_output("rst trunc_err", 32'(trunc_err), 0);
        reset = 1'b1;
        step();

        $display("[TB] single source packet");
        load_pkt(2, 3, 1'b1, 8'h11, 8'h11);
        step();
        check_output("single grant T+1", 32'(grant), 32'b0100);
        check_output("single busy T+1",  32'(busy), 1);
        step();
        check_output("single strobe T+2", 32'(tx_inclk), 1);
        check_output("single data T+2",   32'(tx_data), 32'(FIRST_BYTE));
        run_until_idle(60, "single");
        check_output("single count", pay_q.size(), 3);
        check_output("single b0", 32'(pay_q[0]), 8'h11);
        check_output("single b1", 32'(pay_q[1]), 8'h22);
        check_output("single b2", 32'(pay_q[2]), 8'h33);
        check_output("single rdclk pulses", rd_cnt[2], 3);
        check_output("single grant end", 32'(grant), 0);
`ifdef UART_ARB_HEADER_EN
        check_output("single hdr count", hdr_q.size(), 1);
        check_output("single hdr byte", 32'(hdr_q[0]), 8'hA2);
`else
        check_output("single hdr count", hdr_q.size(), 0);
`endif

        $display("[TB] contention from reset");
        reset = 1'b0;
        #1;
        reset = 1'b1;
        pay_q.delete(); gnt_q.delete(); gnt_cyc.delete(); hdr_q.delete();
        for (int i = 0; i < NS; i++) load_pkt(i, 1, 1'b1, 8'hC0 + i, 1);
        for (int n = 0; n < 60 && gnt_q.size() < 4; n++) step();
        check_output("cont fourth grant", 32'(grant), 32'b1000);
        load_pkt(0, 1, 1'b1, 8'hD0, 1);
        run_until_idle(80, "cont");
        check_output("cont grants", gnt_q.size(), 5);
        check_output("cont g0", gnt_q[0], 0);
        check_output("cont g1", gnt_q[1], 1);
        check_output("cont g2", gnt_q[2], 2);
        check_output("cont g3", gnt_q[3], 3);
        check_output("cont g4", gnt_q[4], 0);
        check_output("cont gap", gnt_cyc[1] - gnt_cyc[0], GRANT_GAP);
        check_output("cont last byte", 32'(pay_q[4]), 8'hD0);
        check_output("cont byte 3", 32'(pay_q[3]), 8'hC3);

        $display("[TB] truncation");
        pay_q.delete();
        give_up[3] = 1'b1;
        load_pkt(3, 6, 1'b0, 8'h61, 1);
        run_until_idle(100, "trunc");
        check_output("trunc count", pay_q.size(), 4);
        check_output("trunc b3", 32'(pay_q[3]), 8'h64);
        check_output("trunc flag", 32'(trunc_err), 1);
        check_output("trunc busy", 32'(busy), 0);
        check_output("trunc grant", 32'(grant), 0);

        $display("[TB] backpressure");
        pay_q.delete();
        base = rd_cnt[1];
        load_pkt(1, 3, 1'b1, 8'h41, 1);
        wait_rd(1, base + 1, "bp first byte");
        tx_ready = 1'b0;
        strobes = 0;
        repeat (20) begin
            step();
            if (tx_inclk) strobes++;
        end
        check_output("bp no strobe", strobes, 0);
        tx_ready = 1'b1;
        step();
        check_output("bp resume strobe", 32'(tx_inclk), 1);
        check_output("bp resume data", 32'(tx_data), 8'h42);
        run_until_idle(60, "bp");
        check_output("bp count", pay_q.size(), 3);
        check_output("bp b2", 32'(pay_q[2]), 8'h43);

        $display("[TB] source stall");
        pay_q.delete();
        base = rd_cnt[2];
        load_pkt(2, 3, 1'b1, 8'h81, 1);
        wait_rd(2, base + 1, "stall first byte");
        src_req[2] = 1'b0;
        strobes = 0;
        lost = 0;
        repeat (7) begin
            step();
            if (tx_inclk) strobes++;
            if (grant != 4'b0100) lost++;
        end
        check_output("stall no strobe", strobes, 0);
        check_output("stall grant held", lost, 0);
        present(2);
        run_until_idle(60, "stall");
        check_output("stall count", pay_q.size(), 3);
        check_output("stall b1", 32'(pay_q[1]), 8'h82);
        check_output("stall b2", 32'(pay_q[2]), 8'h83);

        $display("[TB] reset mid-packet");
        base = rd_cnt[2];
        load_pkt(2, 4, 1'b1, 8'h51, 1);
        wait_rd(2, base + 2, "mid second byte");
        reset = 1'b0;
        #1;
        check_output("mid grant",     32'(grant), 0);
        check_output("mid busy",      32'(busy), 0);
        check_output("mid tx_inclk",  32'(tx_inclk), 0);
        check_output("mid tx_data",   32'(tx_data), 0);
        check_output("mid src_rdclk", 32'(src_rdclk), 0);
        check_output("mid trunc_err", 32'(trunc_err), 0);
        src_req  = '0;
        src_last = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        prev_grant = grant;
        pay_q.delete();
        load_pkt(0, 1, 1'b1, 8'h70, 1);
        load_pkt(3, 1, 1'b1, 8'h73, 1);
        step();
        check_output("post reset grant", 32'(grant), 32'b0001);
        run_until_idle(60, "post reset");
        check_output("post reset count", pay_q.size(), 2);
        check_output("post reset b0", 32'(pay_q[0]), 8'h70);
        check_output("post reset b1", 32'(pay_q[1]), 8'h73);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
